// File: rtl/cmd_arb.sv
// Round-robin arbiter sharing the config-block command port between requesters A and B,
// with a link-loss watchdog on A that injects one emergency-land command per outage.
module cmd_arb #(
   parameter int          WD_BITS = 26,
   parameter logic [7:0]  EMER_OP = 8'h08
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_cmd_rdy,
   input  logic [7:0]  a_cmd,
   input  logic [15:0] a_data,
   output logic        a_clr_cmd_rdy,
   output logic [7:0]  a_resp,
   output logic        a_send_resp,
   input  logic        b_cmd_rdy,
   input  logic [7:0]  b_cmd,
   input  logic [15:0] b_data,
   output logic        b_clr_cmd_rdy,
   output logic [7:0]  b_resp,
   output logic        b_send_resp,
   output logic        cmd_rdy,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        send_resp,
   output logic        link_lost
);

   // state     | meaning
   // IDLE      | no command in flight; arbitrate
   // FWD       | cmd_rdy high, waiting for config block to accept
   // WAIT_RESP | accepted, waiting for the response strobe
   typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_WAIT_RESP} state_t;
   typedef enum logic [1:0] {OWN_A, OWN_B, OWN_INJ} owner_t;

   state_t               r_state, w_state_nxt;
   owner_t               r_owner, w_owner_nxt;
   logic                 r_last_b;
   logic                 r_inj_pend;
   logic                 r_link_lost;
   logic [WD_BITS-1:0]   r_wd;
   logic [7:0]           r_cmd;
   logic [15:0]          r_data;
   logic                 w_grant_a, w_grant_b, w_grant_inj;
   logic                 w_route;
   logic                 w_wd_tc;

   assign w_wd_tc   = &r_wd;
   assign cmd_rdy   = (r_state == ST_FWD);
   assign cmd       = r_cmd;
   assign data      = r_data;
   assign link_lost = r_link_lost;

   always_comb begin
      w_state_nxt   = r_state;
      w_owner_nxt   = r_owner;
      w_grant_a     = 1'b0;
      w_grant_b     = 1'b0;
      w_grant_inj   = 1'b0;
      w_route       = 1'b0;
      a_clr_cmd_rdy = 1'b0;
      b_clr_cmd_rdy = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_inj_pend)
               w_grant_inj = 1'b1;
            else if (a_cmd_rdy && b_cmd_rdy) begin
               w_grant_a = r_last_b;
               w_grant_b = !r_last_b;
            end else begin
               w_grant_a = a_cmd_rdy;
               w_grant_b = b_cmd_rdy;
            end
            if (w_grant_inj) w_owner_nxt = OWN_INJ;
            else if (w_grant_a) w_owner_nxt = OWN_A;
            else if (w_grant_b) w_owner_nxt = OWN_B;
            if (w_grant_inj || w_grant_a || w_grant_b) w_state_nxt = ST_FWD;
         end
         ST_FWD: begin
            if (clr_cmd_rdy) begin
               a_clr_cmd_rdy = (r_owner == OWN_A);
               b_clr_cmd_rdy = (r_owner == OWN_B);
               // A response arriving with the accept completes the transaction at once
               if (send_resp) begin
                  w_route     = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_WAIT_RESP;
               end
            end
         end
         ST_WAIT_RESP: begin
            if (send_resp) begin
               w_route     = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      a_send_resp = w_route && (r_owner == OWN_A);
      b_send_resp = w_route && (r_owner == OWN_B);
      a_resp      = a_send_resp ? resp : 8'h00;
      b_resp      = b_send_resp ? resp : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_owner     <= OWN_A;
         r_last_b    <= 1'b1;
         r_inj_pend  <= 1'b0;
         r_link_lost <= 1'b0;
         r_wd        <= '0;
         r_cmd       <= 8'h00;
         r_data      <= 16'h0000;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         if (w_grant_inj) begin
            r_cmd      <= EMER_OP;
            r_data     <= 16'h0000;
            r_inj_pend <= 1'b0;
         end else if (w_grant_a) begin
            r_cmd    <= a_cmd;
            r_data   <= a_data;
            r_last_b <= 1'b0;
         end else if (w_grant_b) begin
            r_cmd    <= b_cmd;
            r_data   <= b_data;
            r_last_b <= 1'b1;
         end
         // Counter is parked at zero during an outage so only one injection fires per event
         if (a_cmd_rdy) begin
            r_wd        <= '0;
            r_link_lost <= 1'b0;
         end else if (r_link_lost) begin
            r_wd <= '0;
         end else if (w_wd_tc) begin
            r_wd        <= '0;
            r_link_lost <= 1'b1;
            r_inj_pend  <= 1'b1;
         end else begin
            r_wd <= r_wd + WD_BITS'(1);
         end
      end
   end

endmodule

// File: tb/tb_cmd_arb.sv
// Bench for cmd_arb: transaction-level reference model checked every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_cmd_arb;
   localparam int WD = 9;
   localparam int WD_MAX = (1 << WD) - 1;
   localparam byte OA = 8'h41;
   localparam byte OB = 8'h42;
   localparam byte OI = 8'h49;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a_cmd_rdy = 1'b0, b_cmd_rdy = 1'b0;
   logic [7:0] a_cmd = 8'h00, b_cmd = 8'h00;
   logic [15:0] a_data = 16'h0, b_data = 16'h0;
   logic a_clr_cmd_rdy, b_clr_cmd_rdy, a_send_resp, b_send_resp;
   logic [7:0] a_resp, b_resp;
   logic cmd_rdy, link_lost;
   logic [7:0] cmd;
   logic [15:0] data;
   logic clr_cmd_rdy = 1'b0, send_resp = 1'b0;
   logic [7:0] resp = 8'h00;

   int n_pass = 0, n_total = 0;

   cmd_arb #(.WD_BITS(WD), .EMER_OP(8'h08)) dut (
      .clk(clk), .rst(rst),
      .a_cmd_rdy(a_cmd_rdy), .a_cmd(a_cmd), .a_data(a_data),
      .a_clr_cmd_rdy(a_clr_cmd_rdy), .a_resp(a_resp), .a_send_resp(a_send_resp),
      .b_cmd_rdy(b_cmd_rdy), .b_cmd(b_cmd), .b_data(b_data),
      .b_clr_cmd_rdy(b_clr_cmd_rdy), .b_resp(b_resp), .b_send_resp(b_send_resp),
      .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
      .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
      .link_lost(link_lost)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic chk_str(input string nm, input string act, input string exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got '%s' expected '%s'", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: one transaction in flight, phase 0 idle / 1 offered / 2 accepted
   bit   chk_on = 1'b0;
   int   m_phase, m_silent;
   byte  m_owner, m_last;
   bit   m_lost, m_pend;
   logic [7:0]  m_cmd;
   logic [15:0] m_data;

   always @(negedge clk) begin
      bit e_fire, e_aclr, e_bclr, e_as, e_bs;
      byte w;
      if (chk_on) begin
         e_fire = (m_phase == 1 && clr_cmd_rdy && send_resp) || (m_phase == 2 && send_resp);
         e_aclr = (m_phase == 1) && clr_cmd_rdy && (m_owner == OA);
         e_bclr = (m_phase == 1) && clr_cmd_rdy && (m_owner == OB);
         e_as   = e_fire && (m_owner == OA);
         e_bs   = e_fire && (m_owner == OB);
         chk("cmd_port", {cmd_rdy, cmd, data}, {(m_phase == 1), m_cmd, m_data});
         chk("a_side", {a_clr_cmd_rdy, a_send_resp, a_resp}, {e_aclr, e_as, (e_as ? resp : 8'h00)});
         chk("b_side", {b_clr_cmd_rdy, b_send_resp, b_resp}, {e_bclr, e_bs, (e_bs ? resp : 8'h00)});
         chk("link_lost", link_lost, m_lost);
      end
      if (rst) begin
         m_phase = 0; m_silent = 0; m_owner = OA; m_last = OB;
         m_lost = 0; m_pend = 0; m_cmd = 8'h00; m_data = 16'h0;
         chk_on = 1'b1;
      end else if (chk_on) begin
         w = 0;
         if (m_phase == 0) begin
            if (m_pend) w = OI;
            else if (a_cmd_rdy && b_cmd_rdy) w = (m_last == OA) ? OB : OA;
            else if (a_cmd_rdy) w = OA;
            else if (b_cmd_rdy) w = OB;
            if (w == OI) begin m_cmd = 8'h08; m_data = 16'h0; m_pend = 0; end
            if (w == OA) begin m_cmd = a_cmd; m_data = a_data; m_last = OA; end
            if (w == OB) begin m_cmd = b_cmd; m_data = b_data; m_last = OB; end
            if (w != 0) begin m_owner = w; m_phase = 1; end
         end else if (m_phase == 1) begin
            if (clr_cmd_rdy) m_phase = send_resp ? 0 : 2;
         end else if (send_resp) begin
            m_phase = 0;
         end
         if (a_cmd_rdy) begin m_silent = 0; m_lost = 0; end
         else if (m_lost) m_silent = 0;
         else if (m_silent == WD_MAX) begin m_silent = 0; m_lost = 1; m_pend = 1; end
         else m_silent++;
      end
   end

   // Event counters and grant log feeding the literal expectations
   int n_aclr = 0, n_bclr = 0, n_as = 0, n_bs = 0, n_bboth = 0, n_inj = 0;
   logic [7:0] last_a_resp = 8'h00, last_b_resp = 8'h00;
   logic prev_rdy = 1'b0;
   string log_s = "";

   always @(negedge clk) begin
      if (a_clr_cmd_rdy === 1'b1) n_aclr++;
      if (b_clr_cmd_rdy === 1'b1) n_bclr++;
      if (a_send_resp === 1'b1) begin n_as++; last_a_resp = a_resp; end
      if (b_send_resp === 1'b1) begin n_bs++; last_b_resp = b_resp; end
      if (b_clr_cmd_rdy === 1'b1 && b_send_resp === 1'b1) n_bboth++;
      if (cmd_rdy === 1'b1 && prev_rdy !== 1'b1 && cmd === 8'h08) n_inj++;
      if (cmd_rdy === 1'b1 && clr_cmd_rdy) begin
         if (a_clr_cmd_rdy === 1'b1) log_s = {log_s, "A"};
         else if (b_clr_cmd_rdy === 1'b1) log_s = {log_s, "B"};
         else log_s = {log_s, "I"};
      end
      prev_rdy = cmd_rdy;
   end

   task automatic do_reset();
      rst = 1'b1;
      a_cmd_rdy = 0; b_cmd_rdy = 0; clr_cmd_rdy = 0; send_resp = 0; resp = 8'h00;
      repeat (2) tick();
      rst = 1'b0;
      log_s = "";
   endtask

   // Config-block responder; the requester drops cmd_rdy on its clr strobe
   task automatic serve(input int clr_dly, input int resp_dly, input logic [7:0] r, input bit same);
      int k;
      bit da, db;
      k = 0;
      while (cmd_rdy !== 1'b1 && k < 100) begin tick(); k++; end
      if (cmd_rdy !== 1'b1) begin
         n_total++;
         $display("FAIL serve_wait: cmd_rdy got %b after 100 cycles, need 1", cmd_rdy);
         return;
      end
      repeat (clr_dly) tick();
      clr_cmd_rdy = 1'b1;
      if (same) begin send_resp = 1'b1; resp = r; end
      @(negedge clk);
      da = a_clr_cmd_rdy;
      db = b_clr_cmd_rdy;
      tick();
      clr_cmd_rdy = 0; send_resp = 0; resp = 8'h00;
      if (da) a_cmd_rdy = 0;
      if (db) b_cmd_rdy = 0;
      if (!same) begin
         repeat (resp_dly - 1) tick();
         send_resp = 1'b1; resp = r;
         tick();
         send_resp = 0; resp = 8'h00;
      end
   endtask

   int s_aclr, s_bclr, s_as, s_bs, s_both, s_inj;
   task automatic snap();
      s_aclr = n_aclr; s_bclr = n_bclr; s_as = n_as; s_bs = n_bs; s_both = n_bboth; s_inj = n_inj;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation got stuck, need completion");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();
      chk("rst_cmd_rdy", cmd_rdy, 1'b0);
      chk("rst_cmd_data", {cmd, data}, 24'h0);
      chk("rst_link_lost", link_lost, 1'b0);

      // A alone
      a_cmd = 8'h02; a_data = 16'h0123; a_cmd_rdy = 1;
      snap();
      serve(1, 3, 8'hA5, 0);
      chk("a_alone_cmd", {cmd, data}, 24'h020123);
      chk("a_alone_clr_cnt", n_aclr - s_aclr, 1);
      chk("a_alone_resp_cnt", n_as - s_as, 1);
      chk("a_alone_resp", last_a_resp, 8'hA5);
      chk("a_alone_b_quiet", (n_bclr - s_bclr) + (n_bs - s_bs), 0);

      // Both ready: strict alternation starting with A
      do_reset();
      a_cmd = 8'h21; a_data = 16'h2121; b_cmd = 8'h31; b_data = 16'h3131;
      a_cmd_rdy = 1; b_cmd_rdy = 1;
      for (int i = 0; i < 4; i++) begin
         serve(1, 2, 8'h50 + 8'(i), 0);
         if (i == 0) chk("rr_first_cmd", cmd, 8'h21);
         if (i == 1) chk("rr_second_cmd", cmd, 8'h31);
         a_cmd_rdy = 1; b_cmd_rdy = 1;
      end
      chk_str("rr_order", log_s, "ABAB");

      // Watchdog timeout with A silent
      do_reset();
      snap();
      repeat (511) tick();
      chk("wd_before_tc", link_lost, 1'b0);
      tick();
      chk("wd_at_tc", link_lost, 1'b1);
      chk("wd_no_rdy_yet", cmd_rdy, 1'b0);
      tick();
      chk("wd_inj_fwd", {cmd_rdy, cmd, data}, 25'h1_08_0000);
      serve(1, 3, 8'hA5, 0);
      chk("wd_inj_no_strobe", (n_as - s_as) + (n_bs - s_bs), 0);
      repeat (700) tick();
      chk("wd_one_inj", n_inj - s_inj, 1);
      chk("wd_still_lost", link_lost, 1'b1);
      a_cmd = 8'h04; a_data = 16'h0404; a_cmd_rdy = 1;
      serve(1, 2, 8'h44, 0);
      chk("wd_recovered", link_lost, 1'b0);
      chk("wd_one_inj_after", n_inj - s_inj, 1);
      chk_str("wd_order", log_s, "IA");

      // Timeout while B waits for its response; injection beats pending A
      do_reset();
      repeat (500) tick();
      b_cmd = 8'h11; b_data = 16'hBEEF; b_cmd_rdy = 1;
      snap();
      fork
         serve(1, 20, 8'h5A, 0);
         begin
            repeat (16) tick();
            a_cmd = 8'h03; a_data = 16'h0303; a_cmd_rdy = 1;
         end
      join
      chk("tob_b_resp", last_b_resp, 8'h5A);
      chk("tob_b_cnt", n_bs - s_bs, 1);
      chk("tob_lost_cleared", link_lost, 1'b0);
      tick();
      chk("tob_inj_first", {cmd_rdy, cmd}, 9'h1_08);
      serve(1, 2, 8'h66, 0);
      serve(1, 2, 8'h77, 0);
      chk("tob_a_resp", last_a_resp, 8'h77);
      chk_str("tob_order", log_s, "BIA");

      // Stray strobes in IDLE, then clr and send_resp together for B
      do_reset();
      snap();
      clr_cmd_rdy = 1; send_resp = 1; resp = 8'h77;
      tick();
      clr_cmd_rdy = 0; send_resp = 0; resp = 8'h00;
      chk("idle_stray", (n_aclr - s_aclr) + (n_bclr - s_bclr) + (n_as - s_as) + (n_bs - s_bs), 0);
      b_cmd = 8'h12; b_data = 16'h1212; b_cmd_rdy = 1;
      serve(1, 0, 8'h3C, 1);
      chk("same_both_cnt", n_bboth - s_both, 1);
      chk("same_b_resp", last_b_resp, 8'h3C);
      b_cmd = 8'h13; b_data = 16'h1313; b_cmd_rdy = 1;
      serve(1, 2, 8'h3D, 0);
      chk("same_next_ok", last_b_resp, 8'h3D);
      chk("same_next_cmd", cmd, 8'h13);

      // Reset while a command is offered
      do_reset();
      a_cmd = 8'h05; a_data = 16'h0555; a_cmd_rdy = 1;
      tick();
      chk("rstfwd_offer", cmd_rdy, 1'b1);
      rst = 1'b1;
      tick();
      chk("rstfwd_dropped", {cmd_rdy, link_lost, cmd}, 10'h0);
      rst = 1'b0;
      snap();
      serve(1, 2, 8'hC3, 0);
      chk("rstfwd_resp_cnt", n_as - s_as, 1);
      chk("rstfwd_resp", last_a_resp, 8'hC3);
      chk("rstfwd_cmd", {cmd, data}, 24'h050555);

      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
